// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, stall encodings and FSM state codes for the pipeline control unit.
// The optional PIPELINE_CTRL_PERF_EN build uses sat_inc32 for its saturating counters.
package pipeline_ctrl_pkg;

   localparam logic        STOP       = 1'b1;
   localparam logic        NO_STOP    = 1'b0;
   localparam logic        RST_ENABLE = 1'b1;
   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
   localparam logic [31:0] EXC_ERET   = 32'h0000_000e;

   // Bit order: 0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb
   localparam logic [5:0] STALL_VEC_NONE = 6'b000000;
   localparam logic [5:0] STALL_VEC_ID   = 6'b000111;
   localparam logic [5:0] STALL_VEC_EX   = 6'b001111;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_STALL_ID = 2'd1,
      ST_STALL_EX = 2'd2,
      ST_FLUSH    = 2'd3
   } ctrl_state_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] value);
      logic [31:0] result;
      if (value == 32'hffff_ffff) begin
         result = value;
      end else begin
         result = value + 32'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Consecutive-stall counter with a sticky timeout flag that flags a hung multi-cycle EX unit.
module stall_watchdog
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned MAX_STALL = 64,
   parameter int unsigned CNT_W     = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic stall_active,
   output logic timeout
);

   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(MAX_STALL - 1);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_d;
   logic             timeout_q;

   // Count consecutive stall cycles; any non-stall cycle (flush included) restarts the count
   always_comb begin
      cnt_d     = {CNT_W{1'b0}};
      timeout_d = timeout_q;
      if (stall_active) begin
         if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else begin
            cnt_d = cnt_q;
         end
         if (cnt_q == CNT_TRIP) begin
            timeout_d = 1'b1;
         end else begin
            timeout_d = timeout_q;
         end
      end else begin
         cnt_d     = {CNT_W{1'b0}};
         timeout_d = timeout_q;
      end
   end

   // Counter and sticky flag registers; only rst clears the flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         cnt_q     <= {CNT_W{1'b0}};
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: stall arbitration, exception flush/redirect, stall FSM and watchdog.
// Define PIPELINE_CTRL_PERF_EN to add saturating stall/flush performance counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
   parameter int unsigned MAX_STALL  = 64,
   parameter int unsigned CNT_W      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_ex,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        stall_timeout_o,
   output logic [1:0]  ctrl_state_o
`ifdef PIPELINE_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_id_o,
   output logic [31:0] perf_stall_ex_o,
   output logic [31:0] perf_flush_o
`endif
);

   ctrl_state_e sel_s;
   ctrl_state_e state_d;
   ctrl_state_e state_q;
   logic        stall_active_s;

   // Priority decode: exception > EX request > ID request > run
   always_comb begin
      sel_s = ST_RUN;
      if (excepttype_i != ZERO_WORD) begin
         sel_s = ST_FLUSH;
      end else if (stallreq_from_ex) begin
         sel_s = ST_STALL_EX;
      end else if (stallreq_from_id) begin
         sel_s = ST_STALL_ID;
      end else begin
         sel_s = ST_RUN;
      end
   end

   // Same-cycle control outputs so pipeline registers freeze or flush without delay
   always_comb begin
      stall  = STALL_VEC_NONE;
      flush  = NO_STOP;
      new_pc = ZERO_WORD;
      if (rst == RST_ENABLE) begin
         stall  = STALL_VEC_NONE;
         flush  = NO_STOP;
         new_pc = ZERO_WORD;
      end else begin
         case (sel_s)
            ST_FLUSH: begin
               flush  = STOP;
               new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            end
            ST_STALL_EX: stall = STALL_VEC_EX;
            ST_STALL_ID: stall = STALL_VEC_ID;
            default: begin
               stall  = STALL_VEC_NONE;
               flush  = NO_STOP;
               new_pc = ZERO_WORD;
            end
         endcase
      end
   end

   // The FSM simply records which arbitration outcome applied in the previous cycle
   always_comb begin
      state_d = sel_s;
   end

   // State register; ctrl_state_o therefore trails the combinational outputs by one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign ctrl_state_o   = state_q;
   assign stall_active_s = (stall != STALL_VEC_NONE);

   stall_watchdog #(
      .MAX_STALL (MAX_STALL),
      .CNT_W     (CNT_W)
   ) u_stall_watchdog (
      .clk          (clk),
      .rst          (rst),
      .stall_active (stall_active_s),
      .timeout      (stall_timeout_o)
   );

`ifdef PIPELINE_CTRL_PERF_EN
   logic [31:0] perf_id_d;
   logic [31:0] perf_id_q;
   logic [31:0] perf_ex_d;
   logic [31:0] perf_ex_q;
   logic [31:0] perf_flush_d;
   logic [31:0] perf_flush_q;

   // Counters follow the combinational decode, not the lagging state register
   always_comb begin
      perf_id_d    = perf_id_q;
      perf_ex_d    = perf_ex_q;
      perf_flush_d = perf_flush_q;
      case (sel_s)
         ST_STALL_ID: perf_id_d    = sat_inc32(perf_id_q);
         ST_STALL_EX: perf_ex_d    = sat_inc32(perf_ex_q);
         ST_FLUSH:    perf_flush_d = sat_inc32(perf_flush_q);
         default: begin
            perf_id_d    = perf_id_q;
            perf_ex_d    = perf_ex_q;
            perf_flush_d = perf_flush_q;
         end
      endcase
   end

   // Performance counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         perf_id_q    <= ZERO_WORD;
         perf_ex_q    <= ZERO_WORD;
         perf_flush_q <= ZERO_WORD;
      end else begin
         perf_id_q    <= perf_id_d;
         perf_ex_q    <= perf_ex_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall_id_o = perf_id_q;
   assign perf_stall_ex_o = perf_ex_q;
   assign perf_flush_o    = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl with MAX_STALL = 8 and a scoreboard of expected outputs.
module tb_pipeline_ctrl;

   localparam int MAX_STALL = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_from_id;
   logic        stallreq_from_ex;
   logic [31:0] excepttype_i;
   logic [31:0] cp0_epc_i;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        stall_timeout_o;
   logic [1:0]  ctrl_state_o;
`ifdef PIPELINE_CTRL_PERF_EN
   logic [31:0] perf_stall_id_o;
   logic [31:0] perf_stall_ex_o;
   logic [31:0] perf_flush_o;
`endif

   typedef struct packed {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
   } comb_t;

   typedef struct packed {
      logic [1:0] state;
      logic       to;
   } reg_t;

   typedef struct packed {
      logic        do_rst;
      logic        id;
      logic        ex;
      logic [31:0] exc;
   } stim_t;

   comb_t q_comb[$];
   reg_t  q_reg[$];
   int    checks   = 0;
   int    failures = 0;
   int    m_cnt;
   logic  m_to;
   int    m_perf_ex;

   pipeline_ctrl #(
      .EXC_VECTOR (32'h0000_0020),
      .MAX_STALL  (MAX_STALL),
      .CNT_W      (16)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .stallreq_from_id (stallreq_from_id),
      .stallreq_from_ex (stallreq_from_ex),
      .excepttype_i     (excepttype_i),
      .cp0_epc_i        (cp0_epc_i),
      .stall            (stall),
      .flush            (flush),
      .new_pc           (new_pc),
      .stall_timeout_o  (stall_timeout_o),
      .ctrl_state_o     (ctrl_state_o)
`ifdef PIPELINE_CTRL_PERF_EN
      ,
      .perf_stall_id_o  (perf_stall_id_o),
      .perf_stall_ex_o  (perf_stall_ex_o),
      .perf_flush_o     (perf_flush_o)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "bench timeout");
   end

   task automatic model_clear();
      m_cnt     = 0;
      m_to      = 1'b0;
      m_perf_ex = 0;
      q_comb.delete();
      q_reg.delete();
   endtask

   // Called at posedge+1; reset held across one edge, released at posedge+1
   task automatic do_reset();
      rst              = 1'b1;
      stallreq_from_id = 1'b0;
      stallreq_from_ex = 1'b0;
      excepttype_i     = 32'h0;
      cp0_epc_i        = 32'h0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
   endtask

   // Drives one cycle of inputs and pushes the expected results from the reference model
   task automatic drive(input logic i_id, input logic i_ex, input logic [31:0] i_exc,
                        input logic [31:0] i_epc);
      comb_t c;
      reg_t  r;
      stallreq_from_id = i_id;
      stallreq_from_ex = i_ex;
      excepttype_i     = i_exc;
      cp0_epc_i        = i_epc;
      if (i_exc != 32'h0) begin
         c.stall = 6'b000000;
         c.flush = 1'b1;
         c.pc    = (i_exc == 32'h0000_000e) ? i_epc : 32'h0000_0020;
         r.state = 2'd3;
      end else if (i_ex) begin
         c.stall = 6'b001111; c.flush = 1'b0; c.pc = 32'h0; r.state = 2'd2;
         m_perf_ex++;
      end else if (i_id) begin
         c.stall = 6'b000111; c.flush = 1'b0; c.pc = 32'h0; r.state = 2'd1;
      end else begin
         c.stall = 6'b000000; c.flush = 1'b0; c.pc = 32'h0; r.state = 2'd0;
      end
      if (c.stall != 6'b0) begin
         if (m_cnt == MAX_STALL - 1) m_to = 1'b1;
         m_cnt++;
      end else begin
         m_cnt = 0;
      end
      r.to = m_to;
      q_comb.push_back(c);
      q_reg.push_back(r);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      stallreq_from_id = 1'b0;
      stallreq_from_ex = 1'b0;
      excepttype_i = 32'h0;
      cp0_epc_i = 32'h0;
      #1;
      checks++;
      if ({stall, flush, new_pc} !== {6'b0, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL reset_comb got stall=%b flush=%b new_pc=%h want 0/0/0", stall, flush, new_pc);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({ctrl_state_o, stall_timeout_o} !== 3'b000) begin
         failures++;
         $display("FAIL reset_regs got state=%0d timeout=%b want 0/0", ctrl_state_o, stall_timeout_o);
      end
      rst = 1'b0;
      model_clear();
      for (int i = 0; i < 2; i++) begin
         comb_t c;
         reg_t  r;
         drive(1'b0, 1'b0, 32'h0, 32'h0);
         @(negedge clk);
         c = q_comb.pop_front();
         checks++;
         if ({stall, flush, new_pc} !== c) begin
            failures++;
            $display("FAIL idle_comb cyc=%0d got %b/%b/%h want %b/%b/%h", i, stall, flush, new_pc, c.stall, c.flush, c.pc);
         end
         @(posedge clk);
         #1;
         r = q_reg.pop_front();
         checks++;
         if ({ctrl_state_o, stall_timeout_o} !== r) begin
            failures++;
            $display("FAIL idle_regs cyc=%0d got state=%0d to=%b want %0d/%b", i, ctrl_state_o, stall_timeout_o, r.state, r.to);
         end
      end
   endtask

   task automatic test_id_stall();
      for (int i = 0; i < 5; i++) begin
         comb_t c;
         reg_t  r;
         drive(i < 3, 1'b0, 32'h0, 32'h0);
         @(negedge clk);
         c = q_comb.pop_front();
         checks++;
         if ({stall, flush, new_pc} !== c) begin
            failures++;
            $display("FAIL id_stall_comb cyc=%0d got %b/%b/%h want %b/%b/%h", i, stall, flush, new_pc, c.stall, c.flush, c.pc);
         end
         @(posedge clk);
         #1;
         r = q_reg.pop_front();
         checks++;
         if ({ctrl_state_o, stall_timeout_o} !== r) begin
            failures++;
            $display("FAIL id_stall_regs cyc=%0d got state=%0d to=%b want %0d/%b", i, ctrl_state_o, stall_timeout_o, r.state, r.to);
         end
      end
   endtask

   // Both requests, exception overriding them, ERET redirect and back-to-back exceptions
   task automatic test_priority_exc();
      stim_t s[8];
      logic [31:0] epc_vals[8];
      s[0] = '{1'b0, 1'b1, 1'b1, 32'h0};
      s[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_0008};
      s[2] = '{1'b0, 1'b0, 1'b0, 32'h0};
      s[3] = '{1'b0, 1'b0, 1'b0, 32'h0000_000e};
      s[4] = '{1'b0, 1'b0, 1'b0, 32'h0};
      s[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0004};
      s[6] = '{1'b0, 1'b0, 1'b1, 32'h0000_000e};
      s[7] = '{1'b0, 1'b0, 1'b0, 32'h0};
      epc_vals = '{32'h0, 32'h5555_aaaa, 32'h0, 32'h8000_1234, 32'h0, 32'h1111_2222, 32'hbfc0_0380, 32'h0};
      for (int i = 0; i < 8; i++) begin
         comb_t c;
         reg_t  r;
         drive(s[i].id, s[i].ex, s[i].exc, epc_vals[i]);
         @(negedge clk);
         c = q_comb.pop_front();
         checks++;
         if ({stall, flush, new_pc} !== c) begin
            failures++;
            $display("FAIL prio_exc_comb cyc=%0d got %b/%b/%h want %b/%b/%h", i, stall, flush, new_pc, c.stall, c.flush, c.pc);
         end
         @(posedge clk);
         #1;
         r = q_reg.pop_front();
         checks++;
         if ({ctrl_state_o, stall_timeout_o} !== r) begin
            failures++;
            $display("FAIL prio_exc_regs cyc=%0d got state=%0d to=%b want %0d/%b", i, ctrl_state_o, stall_timeout_o, r.state, r.to);
         end
      end
   endtask

   // Trip point, stickiness, clearing by run/flush, and no clearing on ID/EX switch
   task automatic test_watchdog();
      stim_t s[$];
      s.push_back('{1'b1, 1'b0, 1'b1, 32'h0});
      for (int i = 1; i < 8; i++) s.push_back('{1'b0, 1'b0, 1'b1, 32'h0});
      for (int i = 0; i < 3; i++) s.push_back('{1'b0, 1'b0, 1'b0, 32'h0});
      s.push_back('{1'b1, 1'b0, 1'b1, 32'h0});
      for (int i = 1; i < 5; i++) s.push_back('{1'b0, 1'b0, 1'b1, 32'h0});
      s.push_back('{1'b0, 1'b0, 1'b0, 32'h0});
      for (int i = 0; i < 8; i++) s.push_back('{1'b0, 1'b0, 1'b1, 32'h0});
      s.push_back('{1'b1, 1'b1, 1'b0, 32'h0});
      for (int i = 1; i < 4; i++) s.push_back('{1'b0, 1'b1, 1'b0, 32'h0});
      for (int i = 0; i < 4; i++) s.push_back('{1'b0, 1'b0, 1'b1, 32'h0});
      s.push_back('{1'b1, 1'b0, 1'b1, 32'h0});
      for (int i = 1; i < 4; i++) s.push_back('{1'b0, 1'b0, 1'b1, 32'h0});
      s.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_0010});
      for (int i = 0; i < 7; i++) s.push_back('{1'b0, 1'b1, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b0, 1'b0, 32'h0});
      for (int i = 0; i < s.size(); i++) begin
         comb_t c;
         reg_t  r;
         if (s[i].do_rst) do_reset();
         drive(s[i].id, s[i].ex, s[i].exc, 32'h0);
         @(negedge clk);
         c = q_comb.pop_front();
         checks++;
         if ({stall, flush, new_pc} !== c) begin
            failures++;
            $display("FAIL wdog_comb step=%0d got %b/%b/%h want %b/%b/%h", i, stall, flush, new_pc, c.stall, c.flush, c.pc);
         end
         @(posedge clk);
         #1;
         r = q_reg.pop_front();
         checks++;
         if ({ctrl_state_o, stall_timeout_o} !== r) begin
            failures++;
            $display("FAIL wdog_regs step=%0d got state=%0d to=%b want %0d/%b", i, ctrl_state_o, stall_timeout_o, r.state, r.to);
         end
      end
   endtask

   // Asynchronous reset in the middle of an EX stall, X-safety, then counter restart
   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 32'h0, 32'h0);
         @(posedge clk);
         #1;
      end
      drive(1'b0, 1'b1, 32'h0, 32'h0);
      #2;
      checks++;
      if (stall !== 6'b001111) begin
         failures++;
         $display("FAIL async_pre_stall got %b want 001111", stall);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({stall, flush, new_pc, ctrl_state_o, stall_timeout_o} !== {6'b0, 1'b0, 32'h0, 2'd0, 1'b0}) begin
         failures++;
         $display("FAIL async_rst got stall=%b flush=%b pc=%h state=%0d to=%b want all 0", stall, flush, new_pc, ctrl_state_o, stall_timeout_o);
      end
      excepttype_i = 32'hxxxx_xxxx;
      @(posedge clk);
      #1;
      checks++;
      if ({stall, flush, new_pc, ctrl_state_o, stall_timeout_o} !== {6'b0, 1'b0, 32'h0, 2'd0, 1'b0}) begin
         failures++;
         $display("FAIL xsafe_rst got stall=%b flush=%b pc=%h state=%0d to=%b want all 0", stall, flush, new_pc, ctrl_state_o, stall_timeout_o);
      end
`ifdef PIPELINE_CTRL_PERF_EN
      checks++;
      if ({perf_stall_id_o, perf_stall_ex_o, perf_flush_o} !== 96'h0) begin
         failures++;
         $display("FAIL perf_reset got %0d/%0d/%0d want 0/0/0", perf_stall_id_o, perf_stall_ex_o, perf_flush_o);
      end
`endif
      rst = 1'b0;
      excepttype_i = 32'h0;
      model_clear();
      for (int i = 0; i < 8; i++) begin
         comb_t c;
         reg_t  r;
         drive(1'b0, i < 7, 32'h0, 32'h0);
         @(negedge clk);
         c = q_comb.pop_front();
         checks++;
         if ({stall, flush, new_pc} !== c) begin
            failures++;
            $display("FAIL post_rst_comb cyc=%0d got %b/%b/%h want %b/%b/%h", i, stall, flush, new_pc, c.stall, c.flush, c.pc);
         end
         @(posedge clk);
         #1;
         r = q_reg.pop_front();
         checks++;
         if ({ctrl_state_o, stall_timeout_o} !== r) begin
            failures++;
            $display("FAIL post_rst_regs cyc=%0d got state=%0d to=%b want %0d/%b", i, ctrl_state_o, stall_timeout_o, r.state, r.to);
         end
      end
`ifdef PIPELINE_CTRL_PERF_EN
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, i < 5, 32'h0, 32'h0);
         @(posedge clk);
         #1;
      end
      checks++;
      if (perf_stall_ex_o !== 32'(m_perf_ex)) begin
         failures++;
         $display("FAIL perf_stall_ex got %0d want %0d", perf_stall_ex_o, m_perf_ex);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_id_stall();
      test_priority_exc();
      test_watchdog();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
